matmul_ctrl: RTL
================

Name: matmul_ctrl

Overview:
Sequencer for the matrix-multiply datapath. It computes C = A x B for square MAT_DIM x MAT_DIM matrices. A and B are held in two bram instances read through their combinational read ports; results are written into a third bram instance. It runs one start/done job at a time, using a single multiply-accumulate unit and an internal i/j/k loop counter set.

Parameters:
MAT_DIM, 8, matrix dimension; power of two; MAT_DIM*MAT_DIM == 2**BRAM_ADDR_WIDTH
BRAM_ADDR_WIDTH, 6, bram address width; address = row*MAT_DIM + col (row-major)
BRAM_DATA_WIDTH, 32, element width for A, B and C

Ports:
clock  in  1  single system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
busy  out  1  high in CALC, WRITE and DONE
done  out  1  one-cycle pulse when the job completes
a_rd_addr  out  BRAM_ADDR_WIDTH  A bram read address
a_dout  in  BRAM_DATA_WIDTH  A bram read data, combinational from a_rd_addr
b_rd_addr  out  BRAM_ADDR_WIDTH  B bram read address
b_dout  in  BRAM_DATA_WIDTH  B bram read data, combinational from b_rd_addr
c_wr_addr  out  BRAM_ADDR_WIDTH  C bram write address
c_wr_en  out  1  C bram write enable
c_din  out  BRAM_DATA_WIDTH  C bram write data

Behaviour:
- States: IDLE, CALC, WRITE, DONE. Registers: state, i, j, k (each log2(MAT_DIM) bits) and acc (BRAM_DATA_WIDTH bits).
- Reset (asynchronous, any state) sets:
  - state=IDLE; i=j=k=0; acc=0.
  - Outputs: busy=0, done=0, c_wr_en=0, all addresses 0, c_din=0.
- IDLE:
  - start=1 -> CALC, with i=j=k=0.
  - start=0 -> remain in IDLE.
- CALC:
  - a_rd_addr = i*MAT_DIM+k; b_rd_addr = k*MAT_DIM+j (combinational from counters).
  - acc <= (k==0 ? 0 : acc) + (a_dout*b_dout)[BRAM_DATA_WIDTH-1:0].
  - Arithmetic is unsigned and wraps modulo 2**BRAM_DATA_WIDTH; no saturation and no overflow flag.
  - k<MAT_DIM-1 -> k++, stay in CALC.
  - k==MAT_DIM-1 -> k=0, go to WRITE.
- WRITE (exactly one cycle):
  - c_wr_en=1, c_wr_addr=i*MAT_DIM+j, c_din=acc.
  - If j<MAT_DIM-1: j++ and go to CALC.
  - Else if i<MAT_DIM-1: j=0, i++ and go to CALC.
  - Else (i=j=MAT_DIM-1): go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. start is ignored in DONE.
- c_wr_en is 0 in every state other than WRITE. c_wr_addr and c_din are 0 outside WRITE.
- In IDLE, DONE and WRITE the read addresses keep driving the counter-derived values; they are don't-care to the datapath.
- start is ignored whenever busy=1; there is no queueing.
- Timing (cycle 0 = the IDLE cycle with start=1):
  - Element e (row-major order, 0..MAT_DIM^2-1) is written in cycle (MAT_DIM+1)*(e+1).
  - DONE is at cycle (MAT_DIM+1)*MAT_DIM^2+1; with defaults the last write is cycle 576 and done is cycle 577.
  - The earliest next start is accepted at cycle 578.
- Exactly MAT_DIM^2 writes per job, to addresses 0..MAT_DIM^2-1 in ascending order, each written once.
- Reset mid-job:
  - Controller goes straight to IDLE with no further writes; C contents are left partially updated.
  - A later start reruns the full job from element 0.
- A and B must be stable while busy=1. The controller never writes A or B.

Test Plan:
- A=identity, B[n]=n (n=0..63), start pulse at cycle 0 -> 64 writes with C[n]=n; first write cycle 9, last cycle 576; done=1 only at cycle 577; busy low from cycle 578.
- A=B=all 1 -> every C element = 8; c_wr_addr sequence 0,1,...,63; c_wr_en high exactly 64 cycles.
- A=B=all 0xFFFFFFFF -> each product wraps to 1, every C element = 8 (modulo wrap, no saturation).
- A[r][c]=r+1, B[r][c]=c+1 -> C[i][j]=8*(i+1)*(j+1); e.g. C[63]=512, C[9]=32.
- start held high for the entire job plus 3 cycles -> second job begins only at cycle 578 (first IDLE cycle); no extra writes during the first job; done still pulses once per job.
- Assert reset asynchronously mid-cycle at cycle 100 -> busy=0 and c_wr_en=0 immediately without waiting for a clock edge; no writes until a new start; the rerun produces the full correct C and done at start+577.

Source files
------------

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over square MAT_DIM matrices held in three brams.
// One multiply-accumulate per cycle; one C element written every MAT_DIM+1 cycles.
module matmul_ctrl #(
  parameter int MAT_DIM         = 8,
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] a_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] b_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr,
  output logic                       c_wr_en,
  output logic [BRAM_DATA_WIDTH-1:0] c_din
);

  localparam int CW = $clog2(MAT_DIM);
  localparam logic [CW-1:0] LAST = CW'(MAT_DIM - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;
  logic [CW-1:0] w_i_nxt;
  logic [CW-1:0] w_j_nxt;
  logic [CW-1:0] w_k_nxt;

  logic [BRAM_DATA_WIDTH-1:0] r_acc;
  logic [BRAM_DATA_WIDTH-1:0] w_acc_nxt;
  logic [BRAM_DATA_WIDTH-1:0] w_prod;

  // Row-major addressing: power-of-two dimension makes it a concatenation.
  assign a_rd_addr = BRAM_ADDR_WIDTH'({r_i, r_k});
  assign b_rd_addr = BRAM_ADDR_WIDTH'({r_k, r_j});

  // Product truncated to element width: arithmetic wraps.
  assign w_prod = a_dout * b_dout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_acc_nxt   = r_acc;
    busy        = 1'b0;
    done        = 1'b0;
    c_wr_en     = 1'b0;
    c_wr_addr   = '0;
    c_din       = '0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
        end
      end

      CALC: begin
        busy      = 1'b1;
        w_acc_nxt = ((r_k == '0) ? '0 : r_acc) + w_prod;
        if (r_k == LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = WRITE;
        end else begin
          w_k_nxt = r_k + ONE;
        end
      end

      WRITE: begin
        busy      = 1'b1;
        c_wr_en   = 1'b1;
        c_wr_addr = BRAM_ADDR_WIDTH'({r_i, r_j});
        c_din     = r_acc;
        if (r_j != LAST) begin
          w_j_nxt     = r_j + ONE;
          w_state_nxt = CALC;
        end else if (r_i != LAST) begin
          w_j_nxt     = '0;
          w_i_nxt     = r_i + ONE;
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
